// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage.
// Op codes, FSM states and access-size decoding.
package mem_stage_pkg;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LH   = 4'd2;
  localparam logic [3:0] MEMOP_LW   = 4'd3;
  localparam logic [3:0] MEMOP_LD   = 4'd4;
  localparam logic [3:0] MEMOP_LBU  = 4'd5;
  localparam logic [3:0] MEMOP_LHU  = 4'd6;
  localparam logic [3:0] MEMOP_LWU  = 4'd7;
  localparam logic [3:0] MEMOP_SB   = 4'd8;
  localparam logic [3:0] MEMOP_SH   = 4'd9;
  localparam logic [3:0] MEMOP_SW   = 4'd10;
  localparam logic [3:0] MEMOP_SD   = 4'd11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic is_load(
    input logic [3:0] op
  );
    return (op >= MEMOP_LB) && (op <= MEMOP_LWU);
  endfunction

  function automatic logic is_store(
    input logic [3:0] op
  );
    return (op >= MEMOP_SB) && (op <= MEMOP_SD);
  endfunction

  function automatic logic is_signed(
    input logic [3:0] op
  );
    return (op == MEMOP_LB) ||
           (op == MEMOP_LH) ||
           (op == MEMOP_LW);
  endfunction

  function automatic logic [1:0] op_size(
    input logic [3:0] op
  );
    logic [1:0] sz;
    sz = SZ_D;
    unique case (1'b1)
      (op == MEMOP_LB) || (op == MEMOP_LBU) ||
      (op == MEMOP_SB): sz = SZ_B;
      (op == MEMOP_LH) || (op == MEMOP_LHU) ||
      (op == MEMOP_SH): sz = SZ_H;
      (op == MEMOP_LW) || (op == MEMOP_LWU) ||
      (op == MEMOP_SW): sz = SZ_W;
      default:          sz = SZ_D;
    endcase
    return sz;
  endfunction

  function automatic logic [7:0] size_mask(
    input logic [1:0] sz
  );
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [2:0] a
  );
    logic r;
    unique case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = a[0];
      SZ_W:    r = |a[1:0];
      default: r = |a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the memory stage.
// master = pipeline side, slave = memory side.
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [XLEN-1:0]   dmem_req_addr;
  logic [XLEN-1:0]   dmem_req_wdata;
  logic [XLEN/8-1:0] dmem_req_wstrb;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rsp_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_req_we,
    output dmem_req_addr,
    output dmem_req_wdata,
    output dmem_req_wstrb,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_req_we,
    input  dmem_req_addr,
    input  dmem_req_wdata,
    input  dmem_req_wstrb,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Load alignment: shift the doubleword down to the byte offset,
// then sign- or zero-extend the selected size.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  logic [1:0]      size_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    unique case (size_i)
      SZ_B: data_o = {{(XLEN-8){sign_i & shifted[7]}},
                      shifted[7:0]};
      SZ_H: data_o = {{(XLEN-16){sign_i & shifted[15]}},
                      shifted[15:0]};
      SZ_W: data_o = {{(XLEN-32){sign_i & shifted[31]}},
                      shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through plus a load/store FSM
// on a valid/ready data port, stalling upstream while busy.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            expr_mem_valid,
  input  logic [3:0]      expr_mem_mem_op,
  input  logic [XLEN-1:0] expr_mem_alu_result,
  input  logic [XLEN-1:0] expr_mem_store_data,
  input  logic [4:0]      expr_mem_write_back_addr,
  input  logic            expr_mem_is_write_rf,
  input  logic [XLEN-1:0] expr_mem_now_pc,
  input  logic [ILEN-1:0] expr_mem_instruction,
  mem_stage_if.master     dmem,
  output logic            mem_stall_req,
  output logic            mem_misalign,
  output logic [XLEN-1:0] mem_wbpr_write_back_data,
  output logic [4:0]      mem_wbpr_write_back_addr,
  output logic [XLEN-1:0] mempr_wbpr_now_pc,
  output logic [ILEN-1:0] mempr_wbpr_instruction,
  output logic            mempr_wbpr_stall,
  output logic            mempr_wbpr_is_write_rf
);

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] load_q, load_d;

  logic            is_mem;
  logic            mis;
  logic [XLEN-1:0] ld_val;
  logic [1:0]      sz_q;

  assign is_mem = is_load(expr_mem_mem_op) |
                  is_store(expr_mem_mem_op);
  assign mis    = misaligned(op_size(expr_mem_mem_op),
                             expr_mem_alu_result[2:0]);
  assign sz_q   = op_size(op_q);

  mem_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .rdata_i  (dmem.dmem_rsp_rdata),
    .offset_i (addr_q[2:0]),
    .size_i   (sz_q),
    .sign_i   (is_signed(op_q)),
    .data_o   (ld_val)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d                  = state_q;
    op_d                     = op_q;
    addr_d                   = addr_q;
    data_d                   = data_q;
    load_d                   = load_q;
    dmem.dmem_req_valid      = 1'b0;
    mem_stall_req            = 1'b0;
    mem_misalign             = 1'b0;
    mempr_wbpr_stall         = 1'b1;
    mempr_wbpr_is_write_rf   = 1'b0;
    mem_wbpr_write_back_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (expr_mem_valid) begin
          if (!is_mem) begin
            mempr_wbpr_stall         = 1'b0;
            mempr_wbpr_is_write_rf   = expr_mem_is_write_rf;
            mem_wbpr_write_back_data = expr_mem_alu_result;
          end else if (mis) begin
            mem_misalign = 1'b1;
          end else begin
            op_d          = expr_mem_mem_op;
            addr_d        = expr_mem_alu_result;
            data_d        = expr_mem_store_data;
            mem_stall_req = 1'b1;
            state_d       = S_REQ;
          end
        end
      end
      S_REQ: begin
        dmem.dmem_req_valid = 1'b1;
        mem_stall_req       = 1'b1;
        if (dmem.dmem_req_ready) begin
          state_d = is_store(op_q) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        mem_stall_req = 1'b1;
        if (dmem.dmem_rsp_valid) begin
          load_d  = ld_val;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        mempr_wbpr_stall = 1'b0;
        state_d          = S_IDLE;
        if (!is_store(op_q)) begin
          mem_wbpr_write_back_data = load_q;
          mempr_wbpr_is_write_rf   = expr_mem_is_write_rf;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs read as idle while reset is held.
    if (!sys_rst) begin
      dmem.dmem_req_valid      = 1'b0;
      mem_stall_req            = 1'b0;
      mem_misalign             = 1'b0;
      mempr_wbpr_stall         = 1'b1;
      mempr_wbpr_is_write_rf   = 1'b0;
      mem_wbpr_write_back_data = '0;
    end
  end

  assign dmem.dmem_req_we   = is_store(op_q);
  assign dmem.dmem_req_addr = {addr_q[XLEN-1:3], 3'b000};
  assign dmem.dmem_req_wstrb = size_mask(sz_q) << addr_q[2:0];

  always_comb begin
    dmem.dmem_req_wdata = data_q;
    unique case (sz_q)
      SZ_B:    dmem.dmem_req_wdata = {8{data_q[7:0]}};
      SZ_H:    dmem.dmem_req_wdata = {4{data_q[15:0]}};
      SZ_W:    dmem.dmem_req_wdata = {2{data_q[31:0]}};
      default: dmem.dmem_req_wdata = data_q;
    endcase
  end

  assign mem_wbpr_write_back_addr = expr_mem_write_back_addr;
  assign mempr_wbpr_now_pc        = expr_mem_now_pc;
  assign mempr_wbpr_instruction   = expr_mem_instruction;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random ops checked
// against a byte-level memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  op;
  logic [63:0] alu;
  logic [63:0] sdata;
  logic [4:0]  rd;
  logic        wrf;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        stall_req;
  logic        misal;
  logic [63:0] wb_data;
  logic [4:0]  wb_addr;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic        wb_stall;
  logic        wb_wrf;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(64)) dmem ();

  mem_stage #(
    .XLEN (64),
    .ILEN (32)
  ) dut (
    .sys_clk                  (clk),
    .sys_rst                  (rst_n),
    .expr_mem_valid           (valid),
    .expr_mem_mem_op          (op),
    .expr_mem_alu_result      (alu),
    .expr_mem_store_data      (sdata),
    .expr_mem_write_back_addr (rd),
    .expr_mem_is_write_rf     (wrf),
    .expr_mem_now_pc          (pc),
    .expr_mem_instruction     (instr),
    .dmem                     (dmem),
    .mem_stall_req            (stall_req),
    .mem_misalign             (misal),
    .mem_wbpr_write_back_data (wb_data),
    .mem_wbpr_write_back_addr (wb_addr),
    .mempr_wbpr_now_pc        (pc_o),
    .mempr_wbpr_instruction   (instr_o),
    .mempr_wbpr_stall         (wb_stall),
    .mempr_wbpr_is_write_rf   (wb_wrf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  logic [63:0] mem_m [longint];

  function automatic logic [63:0] rd_dw(input longint k);
    if (!mem_m.exists(k)) mem_m[k] = {$urandom, $urandom};
    return mem_m[k];
  endfunction

  function automatic int nbytes(input logic [3:0] o);
    case (o)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 1;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2;
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: return 4;
      default:                       return 8;
    endcase
  endfunction

  task automatic exec(input logic v, input logic [3:0] o,
                      input logic [63:0] a, input logic [63:0] sd,
                      input logic [4:0] r, input logic w,
                      input int rdy_dly, input int rsp_dly);
    int          nb, off;
    logic        ld, st, sgn;
    longint      key;
    logic [63:0] dw, ev, ewd;
    logic [15:0] t;
    logic [7:0]  est;
    ld  = (o >= MEMOP_LB) && (o <= MEMOP_LWU);
    st  = (o >= MEMOP_SB) && (o <= MEMOP_SD);
    sgn = (o == MEMOP_LB) || (o == MEMOP_LH) || (o == MEMOP_LW);
    nb  = nbytes(o);
    off = int'(a[2:0]);
    key = longint'(a[63:3]);
    @(negedge clk);
    valid = v; op = o; alu = a; sdata = sd; rd = r; wrf = w;
    pc = {$urandom, $urandom}; instr = $urandom;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    #2;
    chk("pc_pass", pc_o, pc);
    chk("instr_pass", {32'b0, instr_o}, {32'b0, instr});
    chk("rd_pass", {59'b0, wb_addr}, {59'b0, r});
    if (!v) begin
      chk("bub_stall", wb_stall, 1'b1);
      chk("bub_sreq", stall_req, 1'b0);
      chk("bub_wrf", wb_wrf, 1'b0);
      return;
    end
    if (!ld && !st) begin
      chk("alu_data", wb_data, a);
      chk("alu_stall", wb_stall, 1'b0);
      chk("alu_sreq", stall_req, 1'b0);
      chk("alu_wrf", wb_wrf, w);
      return;
    end
    if ((off % nb) != 0) begin
      chk("mis_pulse", misal, 1'b1);
      chk("mis_req", dmem.dmem_req_valid, 1'b0);
      chk("mis_stall", wb_stall, 1'b1);
      chk("mis_sreq", stall_req, 1'b0);
      return;
    end
    chk("idle_sreq", stall_req, 1'b1);
    chk("idle_stall", wb_stall, 1'b1);
    chk("idle_req", dmem.dmem_req_valid, 1'b0);
    chk("idle_mis", misal, 1'b0);
    t   = 16'((1 << nb) - 1) << off;
    est = t[7:0];
    for (int i = 0; i < 8; i++) ewd[8*i +: 8] = sd[8*(i % nb) +: 8];
    for (int c = 0; c <= rdy_dly; c++) begin
      @(negedge clk);
      dmem.dmem_req_ready = (c == rdy_dly);
      #2;
      chk("req_valid", dmem.dmem_req_valid, 1'b1);
      chk("req_addr", dmem.dmem_req_addr, a & ~64'h7);
      chk("req_we", dmem.dmem_req_we, st);
      if (st) begin
        chk("req_wstrb", {56'b0, dmem.dmem_req_wstrb}, {56'b0, est});
        chk("req_wdata", dmem.dmem_req_wdata, ewd);
      end
      chk("req_sreq", stall_req, 1'b1);
      chk("req_stall", wb_stall, 1'b1);
    end
    dw = rd_dw(key);
    ev = '0;
    if (ld) begin
      for (int c = 0; c <= rsp_dly; c++) begin
        @(negedge clk);
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = (c == rsp_dly);
        dmem.dmem_rsp_rdata = (c == rsp_dly) ? dw : {$urandom, $urandom};
        #2;
        chk("wait_req", dmem.dmem_req_valid, 1'b0);
        chk("wait_sreq", stall_req, 1'b1);
        chk("wait_stall", wb_stall, 1'b1);
      end
      for (int i = 0; i < nb; i++) ev[8*i +: 8] = dw[8*(off+i) +: 8];
      if (sgn && nb < 8 && ev[8*nb-1])
        for (int j = nb; j < 8; j++) ev[8*j +: 8] = 8'hFF;
    end else begin
      for (int i = 0; i < nb; i++) dw[8*(off+i) +: 8] = sd[8*i +: 8];
      mem_m[key] = dw;
    end
    @(negedge clk);
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = {$urandom, $urandom};
    #2;
    chk("done_stall", wb_stall, 1'b0);
    chk("done_sreq", stall_req, 1'b0);
    chk("done_data", wb_data, ev);
    chk("done_wrf", wb_wrf, ld ? w : 1'b0);
    chk("done_req", dmem.dmem_req_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = MEMOP_NONE;
    alu = '0; sdata = '0; rd = '0; wrf = 1'b0;
    pc = '0; instr = '0;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", dmem.dmem_req_valid, 1'b0);
    chk("rst_sreq", stall_req, 1'b0);
    chk("rst_mis", misal, 1'b0);
    chk("rst_stall", wb_stall, 1'b1);
    chk("rst_wrf", wb_wrf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    exec(1'b1, MEMOP_NONE, 64'h1234, 64'h0, 5'd5, 1'b1, 0, 0);
    mem_m[longint'(64'h103 >> 3)] = 64'h0000_0000_8000_0000;
    exec(1'b1, MEMOP_LB, 64'h103, 64'h0, 5'd7, 1'b1, 1, 1);
    exec(1'b1, MEMOP_LBU, 64'h103, 64'h0, 5'd7, 1'b1, 0, 0);
    exec(1'b1, MEMOP_SH, 64'h206, 64'hBEEF, 5'd3, 1'b1, 3, 0);
    exec(1'b1, MEMOP_LH, 64'h206, 64'h0, 5'd4, 1'b1, 0, 0);
    exec(1'b1, MEMOP_LW, 64'h102, 64'h0, 5'd6, 1'b1, 0, 0);
    exec(1'b0, MEMOP_NONE, 64'h0, 64'h0, 5'd0, 1'b0, 0, 0);

    // reset while the load is waiting for its response
    @(negedge clk);
    valid = 1'b1; op = MEMOP_LD; alu = 64'h1010;
    #2;
    chk("rw_sreq0", stall_req, 1'b1);
    @(negedge clk);
    dmem.dmem_req_ready = 1'b1;
    #2;
    chk("rw_req", dmem.dmem_req_valid, 1'b1);
    @(negedge clk);
    dmem.dmem_req_ready = 1'b0;
    #2;
    chk("rw_wait", stall_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rsp_rdata = 64'hDEAD_BEEF_0000_1111;
    #2;
    chk("rw_req_off", dmem.dmem_req_valid, 1'b0);
    chk("rw_sreq", stall_req, 1'b0);
    chk("rw_stall", wb_stall, 1'b1);
    chk("rw_wrf", wb_wrf, 1'b0);
    chk("rw_mis", misal, 1'b0);
    @(negedge clk);
    dmem.dmem_rsp_valid = 1'b0;
    #2;
    chk("rw_ignored", wb_stall, 1'b1);
    chk("rw_idle", stall_req, 1'b0);

    exec(1'b1, MEMOP_LD, 64'h1008, 64'h0, 5'd9, 1'b1, 0, 0);
    exec(1'b1, MEMOP_LD, 64'h1010, 64'h0, 5'd10, 1'b1, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [63:0] a;
      a = 64'h1000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~64'h7;
      exec(($urandom_range(0, 9) != 0),
           4'($urandom_range(0, 11)), a,
           {$urandom, $urandom}, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register (mem_wb).
- Passes ALU results straight through to write-back.
- Executes loads and stores over a valid/ready data-memory port, using a small FSM.
- Stalls upstream stages while a memory access is outstanding.
- Produces the write-back data, destination address and bubble flag consumed by mem_wb.

Parameters:
- XLEN, 64, datapath width; equals the `width macro range.
- ILEN, 32, instruction width; equals the `instr_width macro range.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous reset, active-low.
- expr_mem_valid  in  1  EX/MEM holds a valid instruction.
- expr_mem_mem_op  in  4  memory op code (MEMOP_* constants).
- expr_mem_alu_result  in  XLEN  ALU result; also the effective address.
- expr_mem_store_data  in  XLEN  rs2 value for stores.
- expr_mem_write_back_addr  in  5  rd.
- expr_mem_is_write_rf  in  1  instruction writes the register file.
- expr_mem_now_pc  in  XLEN  PC.
- expr_mem_instruction  in  ILEN  instruction word.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = store.
- dmem_req_addr  out  XLEN  address, aligned down to 8 bytes.
- dmem_req_wdata  out  XLEN  store data, shifted into byte lanes.
- dmem_req_wstrb  out  XLEN/8  byte strobes.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_rdata  in  XLEN  load data (aligned doubleword).
- mem_stall_req  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- mem_misalign  out  1  one-cycle pulse on a misaligned access.
- mem_wbpr_write_back_data  out  XLEN  write-back value.
- mem_wbpr_write_back_addr  out  5  rd.
- mempr_wbpr_now_pc  out  XLEN  PC.
- mempr_wbpr_instruction  out  ILEN  instruction word.
- mempr_wbpr_stall  out  1  1 = bubble, no architectural effect.
- mempr_wbpr_is_write_rf  out  1  RF write enable; forced 0 when the stall flag is 1.

Behaviour:
- Reset (sys_rst==0 at a clock edge):
  - state goes to IDLE and any outstanding request is abandoned.
  - dmem_req_valid=0, mem_stall_req=0, mem_misalign=0, mempr_wbpr_stall=1, mempr_wbpr_is_write_rf=0.
  - Latched address, data and op registers clear to 0.
  - Reset mid-access: the request drops the cycle after reset and the response is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Valid, non-memory op (MEMOP_NONE): outputs are combinational pass-through, data = alu_result, stall flag = 0. Zero added latency.
  - Valid memory op, aligned: latch op/address/data and go to REQ. mem_stall_req=1 combinationally; the output is a bubble.
  - Misaligned (halfword addr[0]!=0, word addr[1:0]!=0, doubleword addr[2:0]!=0): mem_misalign=1, no request, output is a bubble, stay in IDLE.
  - expr_mem_valid=0: output is a bubble.
- REQ:
  - dmem_req_valid=1. Address, wdata, wstrb and we are held stable until dmem_req_ready.
  - On ready: store goes to DONE, load goes to WAIT.
  - mem_stall_req=1, output is a bubble.
- WAIT:
  - On dmem_rsp_valid, capture the extracted load value and go to DONE. A response in the same cycle as ready is not allowed; one cycle minimum.
  - mem_stall_req=1, output is a bubble.
- DONE:
  - mem_stall_req=0 and stall flag = 0.
  - Write-back data = captured load value (store: 0, with is_write_rf forced 0).
  - Go to IDLE; the upstream instruction advances this same cycle.
- Store lanes:
  - wdata = store_data replicated across lanes.
  - wstrb = size mask shifted left by addr[2:0] (SB 1, SH 2'b11, SW 4'hF, SD 8'hFF).
- Load extraction:
  - Shift rdata right by addr[2:0]*8.
  - Take the low 8/16/32/64 bits.
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend.
- Writes with rd=0 pass through unchanged; the register file ignores x0.
- PC, instruction, rd and is_write_rf are taken from the EX/MEM inputs. They stay stable because EX/MEM is frozen while mem_stall_req is high.

Decomposition:
- Package: MEMOP_* 4-bit codes (NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD), FSM state encodings, size-decode helper constants.
- Sub-module: mem_load_align, combinational shift plus sign/zero extend. It is reused later by a cache.

Test Plan:
- ALU op: alu_result=0x1234, rd=5, is_write_rf=1 -> same-cycle data 0x1234, addr 5, stall flag 0, mem_stall_req 0.
- LB at addr 0x103, rdata=0x0000_0000_8000_0000 -> shifted byte 0x80, write-back 0xFFFF_FFFF_FFFF_FF80. The stall flag is 0 only in DONE; LBU gives 0x80.
- SH store_data=0xBEEF at addr 0x206, ready delayed 3 cycles -> req held stable 3 cycles, addr 0x200, wstrb 0xC0, wdata lanes [63:48]=0xBEEF, then DONE with is_write_rf=0.
- LW at addr 0x102 -> mem_misalign pulse, no dmem_req_valid, bubble, no stall beyond that cycle.
- Reset during WAIT, then a late dmem_rsp_valid -> FSM IDLE, response ignored, all outputs at reset values.
- Back-to-back LD, LD with ready=1 and rsp one cycle later -> each load takes 4 cycles (IDLE, REQ, WAIT, DONE), correct data in order, no lost instruction.
